// File: rtl/button_conditioner_if.sv
// Signal bundle between the raw push buttons and the conditioned on/off request outputs.
interface button_conditioner_if;
    logic btn_on_raw;
    logic btn_off_raw;
    logic j;
    logic k;
    logic on_level;
    logic off_level;
    logic conflict;

    modport master (
        output btn_on_raw, btn_off_raw,
        input  j, k, on_level, off_level, conflict
    );

    modport slave (
        input  btn_on_raw, btn_off_raw,
        output j, k, on_level, off_level, conflict
    );
endinterface

// File: rtl/button_conditioner.sv
// Synchronise, debounce and edge-detect two raw buttons into j/k request pulses,
// with OFF taking priority when both presses are accepted on the same edge.

// state           | meaning
// RELEASED        | level 0, input agrees, counter idle
// PRESS_PENDING   | level 0, input high, counting towards commit
// PRESSED         | level 1, input agrees, counter idle
// RELEASE_PENDING | level 1, input low, counting towards commit
module button_conditioner_chan #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_lvl,
    output logic o_rise
);
    // Encoding is {lvl, counting}, so bit 1 is the debounced level itself.
    typedef enum logic [1:0] {
        RELEASED        = 2'b00,
        PRESS_PENDING   = 2'b01,
        PRESSED         = 2'b10,
        RELEASE_PENDING = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] TC = CNT_W'(DEBOUNCE_CYCLES);

    logic [1:0]       r_sync;
    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_s;
    logic             w_lvl;
    logic             w_rise;

    assign w_s   = r_sync[1];
    assign w_lvl = r_state[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= 2'b00;
            r_state <= RELEASED;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[0], i_raw};
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_rise       = 1'b0;
        if (w_s == w_lvl) begin
            w_cnt_next   = '0;
            w_next_state = w_lvl ? PRESSED : RELEASED;
        end else if (r_cnt + 1'b1 == TC) begin
            w_cnt_next   = '0;
            w_next_state = w_s ? PRESSED : RELEASED;
            w_rise       = w_s;
        end else begin
            w_cnt_next   = r_cnt + 1'b1;
            w_next_state = w_lvl ? RELEASE_PENDING : PRESS_PENDING;
        end
    end

    assign o_lvl  = w_lvl;
    assign o_rise = w_rise;
endmodule

module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    button_conditioner_if.slave   bus
);
    logic w_on_lvl;
    logic w_on_rise;
    logic w_off_lvl;
    logic w_off_rise;
    logic r_j;
    logic r_k;
    logic r_conflict;

    button_conditioner_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_on (
        .clk    (clk),
        .reset  (reset),
        .i_raw  (bus.btn_on_raw),
        .o_lvl  (w_on_lvl),
        .o_rise (w_on_rise)
    );

    button_conditioner_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_off (
        .clk    (clk),
        .reset  (reset),
        .i_raw  (bus.btn_off_raw),
        .o_lvl  (w_off_lvl),
        .o_rise (w_off_rise)
    );

    // OFF wins a same-edge tie so the load is never commanded on by a conflicting press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_j        <= 1'b0;
            r_k        <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_j        <= w_on_rise & ~w_off_rise;
            r_k        <= w_off_rise;
            r_conflict <= w_on_rise & w_off_rise;
        end
    end

    assign bus.j         = r_j;
    assign bus.k         = r_k;
    assign bus.conflict  = r_conflict;
    assign bus.on_level  = w_on_lvl;
    assign bus.off_level = w_off_lvl;
endmodule
